// File: rtl/hood_controller_multi.sv
// hood_controller_multi: range-hood mode controller with N smoke levels, self-clean countdown and short/long menu press detection.
// Optional top-level dwell timeout enabled by defining HOOD_TOP_TIMEOUT_EN.
module hood_controller_multi #(
  parameter int NUM_LEVELS        = 3,
  parameter int TICK_DIV          = 1000000,
  parameter int DEBOUNCE_TICKS    = 2,
  parameter int LONG_PRESS_TICKS  = 200,
  parameter int CLEAN_W           = 16,
  parameter int TOP_TIMEOUT_TICKS = 6000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  power_on,
  input  logic                  menu,
  input  logic [NUM_LEVELS:0]   mode_sel,
  input  logic [CLEAN_W-1:0]    clean_delay,
  output logic [1:0]            state,
  output logic [NUM_LEVELS-1:0] smoke_lvl,
  output logic [CLEAN_W-1:0]    clean_remaining,
  output logic                  clean_done,
  output logic                  short_press,
  output logic                  long_press
);
  localparam int DW  = $clog2(TICK_DIV + 1);
  localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW  = $clog2(LONG_PRESS_TICKS + 1);
  localparam logic [DW-1:0]     DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [DBW-1:0]    DBC_LAST  = DBW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0]     HOLD_MAX  = HW'(LONG_PRESS_TICKS);
  localparam logic [NUM_LEVELS:0] CLEAN_SEL = {1'b1, {NUM_LEVELS{1'b0}}};

  typedef enum logic [1:0] {OFF = 2'b00, STANDBY = 2'b01, SMOKING = 2'b10, CLEANING = 2'b11} state_t;

  logic [DW-1:0]  div_q, div_d;
  logic           tick;
  logic [1:0]     sync_q, sync_d;
  logic           db_q, db_d, db_prev_q;
  logic [DBW-1:0] dbc_q, dbc_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic           short_q, short_d, long_q, long_d;
  logic           rise, fall;

  state_t                  state_q, state_d;
  logic [NUM_LEVELS-1:0]   smoke_q, smoke_d;
  logic [CLEAN_W-1:0]      rem_q, rem_d;
  logic                    done_q, done_d;
  logic                    lvl_ok, cln_ok, tmo;

  // Prescaler, menu synchroniser/debouncer and hold-time press classifier.
  always_comb begin
    tick    = div_q == DIV_LAST;
    div_d   = tick ? '0 : div_q + 1'b1;
    sync_d  = {sync_q[0], menu};
    db_d    = db_q;
    dbc_d   = dbc_q;
    if (tick) begin
      if (sync_q[1] == db_q) dbc_d = '0;
      else if (dbc_q == DBC_LAST) begin
        db_d  = ~db_q;
        dbc_d = '0;
      end else dbc_d = dbc_q + 1'b1;
    end
    rise    = db_q & ~db_prev_q;
    fall    = ~db_q & db_prev_q;
    hold_d  = rise ? '0 : (db_q && tick && hold_q != HOLD_MAX) ? hold_q + 1'b1 : hold_q;
    long_d  = !rise && db_q && tick && hold_q == HOLD_MAX - 1'b1;
    short_d = fall && hold_q != HOLD_MAX;
  end

  // Registers for the input path; everything clears while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      sync_q    <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dbc_q     <= '0;
      hold_q    <= '0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      sync_q    <= sync_d;
      db_q      <= db_d;
      db_prev_q <= db_q;
      dbc_q     <= dbc_d;
      hold_q    <= hold_d;
      short_q   <= short_d;
      long_q    <= long_d;
    end
  end

`ifdef HOOD_TOP_TIMEOUT_EN
  localparam int TW = $clog2(TOP_TIMEOUT_TICKS + 1);
  logic [TW-1:0] dwell_q, dwell_d;
  assign tmo = state_q == SMOKING && smoke_q[NUM_LEVELS-1] && tick && dwell_q == TW'(TOP_TIMEOUT_TICKS - 1);
  // Dwell counter runs only while the top level stays selected; any other move clears it.
  always_comb begin
    dwell_d = (state_q == SMOKING && smoke_q[NUM_LEVELS-1] && state_d == SMOKING && smoke_d[NUM_LEVELS-1]) ? dwell_q + TW'(tick) : '0;
  end
  // Dwell counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dwell_q <= '0;
    else        dwell_q <= dwell_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // Mode FSM: power loss beats long press, which beats short press, which beats timers.
  always_comb begin
    lvl_ok  = $onehot(mode_sel) && !mode_sel[NUM_LEVELS];
    cln_ok  = mode_sel == CLEAN_SEL;
    state_d = state_q;
    smoke_d = smoke_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (!power_on) begin
      state_d = OFF;
      smoke_d = '0;
      rem_d   = '0;
    end else if (state_q == OFF) state_d = STANDBY;
    else if (long_q) begin
      state_d = STANDBY;
      smoke_d = '0;
      rem_d   = '0;
    end else if (state_q == STANDBY) begin
      if (short_q && lvl_ok) begin
        state_d = SMOKING;
        smoke_d = mode_sel[NUM_LEVELS-1:0];
      end else if (short_q && cln_ok) begin
        state_d = clean_delay == '0 ? STANDBY : CLEANING;
        rem_d   = clean_delay;
        done_d  = clean_delay == '0;
      end
    end else if (state_q == SMOKING) begin
      if (short_q) begin
        state_d = (lvl_ok && mode_sel[NUM_LEVELS-1:0] != smoke_q) ? SMOKING : STANDBY;
        smoke_d = (lvl_ok && mode_sel[NUM_LEVELS-1:0] != smoke_q) ? mode_sel[NUM_LEVELS-1:0] : '0;
      end else if (tmo) begin
        state_d = NUM_LEVELS == 1 ? STANDBY : SMOKING;
        smoke_d = smoke_q >> 1;
      end
    end else if (tick) begin
      rem_d   = rem_q - 1'b1;
      done_d  = rem_q == CLEAN_W'(1);
      state_d = rem_q == CLEAN_W'(1) ? STANDBY : CLEANING;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= OFF;
      smoke_q <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      smoke_q <= smoke_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign state           = state_q;
  assign smoke_lvl       = smoke_q;
  assign clean_remaining = rem_q;
  assign clean_done      = done_q;
  assign short_press     = short_q;
  assign long_press      = long_q;
endmodule

// File: tb/tb_hood_controller_multi.sv
// tb_hood_controller_multi: vector table plus press-event scoreboard for hood_controller_multi.
module tb_hood_controller_multi;
  localparam int N = 3;
  logic clk = 1'b0, reset = 1'b1, power_on = 1'b0, menu = 1'b0;
  logic [N:0] mode_sel = '0;
  logic [15:0] clean_delay = '0;
  logic [1:0] state;
  logic [N-1:0] smoke_lvl;
  logic [15:0] clean_remaining;
  logic clean_done, short_press, long_press;

  hood_controller_multi #(.NUM_LEVELS(N), .TICK_DIV(4), .DEBOUNCE_TICKS(2), .LONG_PRESS_TICKS(10),
                          .CLEAN_W(16), .TOP_TIMEOUT_TICKS(20)) dut (
    .clk(clk), .reset(reset), .power_on(power_on), .menu(menu), .mode_sel(mode_sel),
    .clean_delay(clean_delay), .state(state), .smoke_lvl(smoke_lvl), .clean_remaining(clean_remaining),
    .clean_done(clean_done), .short_press(short_press), .long_press(long_press));

  always #5 clk = ~clk;

  typedef enum {EV_SHORT, EV_LONG, EV_DONE} ev_t;
  ev_t exp_q[$];
  int n_chk = 0, n_fail = 0;

  typedef struct {
    string name;
    logic [N:0] sel;
    logic [15:0] dly;
    int hold;
    int events;
    int settle;
    logic [1:0] ex_state;
    logic [N-1:0] ex_smoke;
  } vec_t;
  vec_t vecs[9];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic see(ev_t e);
    ev_t x;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL pulse: got %s, expected no pulse", e.name());
    end else begin
      x = exp_q.pop_front();
      if (x != e) begin
        n_fail++;
        $display("FAIL pulse: got %s, expected %s", e.name(), x.name());
      end
    end
  endtask

  always @(negedge clk) if (reset) begin
    if (short_press) see(EV_SHORT);
    if (long_press)  see(EV_LONG);
    if (clean_done)  see(EV_DONE);
  end

  task automatic press(int ticks);
    @(negedge clk) menu = 1'b1;
    repeat (ticks * 4) @(negedge clk);
    menu = 1'b0;
  endtask

  task automatic settle(int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic wait_state(logic [1:0] s, string name);
    for (int i = 0; i < 200 && state !== s; i++) @(negedge clk);
    check(name, state, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev;
    vecs[0] = '{"lvl2",         4'b0010, 16'd0, 3,  1, 30, 2'b10, 3'b010};
    vecs[1] = '{"lvl3",         4'b0100, 16'd0, 3,  1, 30, 2'b10, 3'b100};
    vecs[2] = '{"long_smoke",   4'b0100, 16'd0, 15, 2, 30, 2'b01, 3'b000};
    vecs[3] = '{"multihot",     4'b0011, 16'd0, 3,  1, 30, 2'b01, 3'b000};
    vecs[4] = '{"zerohot",      4'b0000, 16'd0, 3,  1, 30, 2'b01, 3'b000};
    vecs[5] = '{"lvl1",         4'b0001, 16'd0, 3,  1, 30, 2'b10, 3'b001};
    vecs[6] = '{"same_lvl_off", 4'b0001, 16'd0, 3,  1, 30, 2'b01, 3'b000};
    vecs[7] = '{"clean5",       4'b1000, 16'd5, 3,  3, 60, 2'b01, 3'b000};
    vecs[8] = '{"clean0",       4'b1000, 16'd0, 3,  3, 30, 2'b01, 3'b000};

    #1 reset = 1'b0;
    #11;
    check("rst_state", state, 2'b00);
    check("rst_smoke", smoke_lvl, 3'b000);
    check("rst_rem", clean_remaining, 16'd0);
    check("rst_pulses", {clean_done, short_press, long_press}, 3'b000);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) check("off_no_power", state, 2'b00);
    power_on = 1'b1;
    @(negedge clk) check("power_standby", state, 2'b01);

    for (int v = 0; v < 9; v++) begin
      mode_sel = vecs[v].sel;
      clean_delay = vecs[v].dly;
      if (vecs[v].events == 1 || vecs[v].events == 3) exp_q.push_back(EV_SHORT);
      if (vecs[v].events == 2) exp_q.push_back(EV_LONG);
      if (vecs[v].events == 3) exp_q.push_back(EV_DONE);
      press(vecs[v].hold);
      settle(vecs[v].settle);
      check({vecs[v].name, "_state"}, state, vecs[v].ex_state);
      check({vecs[v].name, "_smoke"}, smoke_lvl, vecs[v].ex_smoke);
      check({vecs[v].name, "_rem"}, clean_remaining, 16'd0);
    end

    mode_sel = 4'b1000; clean_delay = 16'd5;
    exp_q.push_back(EV_SHORT); exp_q.push_back(EV_DONE);
    press(3);
    wait_state(2'b11, "cd_enter");
    check("cd_rem5", clean_remaining, 16'd5);
    for (int v = 4; v >= 0; v--) begin
      prev = clean_remaining;
      for (int i = 0; i < 12 && clean_remaining === prev; i++) @(negedge clk);
      check("cd_step", clean_remaining, v);
    end
    check("cd_exit_state", state, 2'b01);
    settle(20);

    mode_sel = 4'b1000; clean_delay = 16'd200;
    exp_q.push_back(EV_SHORT);
    press(3);
    wait_state(2'b11, "lc_enter");
    exp_q.push_back(EV_LONG);
    press(15);
    settle(30);
    check("lc_state", state, 2'b01);
    check("lc_rem", clean_remaining, 16'd0);

    mode_sel = 4'b0010;
    @(negedge clk) menu = 1'b1;
    repeat (3) @(negedge clk);
    menu = 1'b0;
    settle(30);
    check("glitch_state", state, 2'b01);

    exp_q.push_back(EV_SHORT);
    @(negedge clk) menu = 1'b1;
    repeat (12) @(negedge clk);
    menu = 1'b0;
    for (int i = 0; i < 60 && !short_press; i++) @(negedge clk);
    check("pwr_short_seen", short_press, 1'b1);
    power_on = 1'b0;
    @(negedge clk) check("pwr_off_state", state, 2'b00);
    power_on = 1'b1;
    @(negedge clk) check("pwr_back", state, 2'b01);
    settle(20);

    mode_sel = 4'b1000; clean_delay = 16'd20;
    exp_q.push_back(EV_SHORT);
    press(3);
    for (int i = 0; i < 400 && !(state === 2'b11 && clean_remaining === 16'd7); i++) @(negedge clk);
    check("mid_rem7", clean_remaining, 16'd7);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_state", state, 2'b00);
    check("mid_rst_rem", clean_remaining, 16'd0);
    check("mid_rst_rest", {smoke_lvl, clean_done, short_press, long_press}, 6'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) check("mid_rel_state", state, 2'b01);
    settle(10);

`ifdef HOOD_TOP_TIMEOUT_EN
    mode_sel = 4'b0100;
    exp_q.push_back(EV_SHORT);
    press(3);
    settle(30);
    check("tmo_top", smoke_lvl, 3'b100);
    for (int i = 0; i < 200 && smoke_lvl === 3'b100; i++) @(negedge clk);
    check("tmo_lvl", smoke_lvl, 3'b010);
    check("tmo_state", state, 2'b10);
`endif

    settle(10);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hood_controller_multi.md
Name: hood_controller_multi

Overview:
- Second-generation range-hood mode controller with N smoke levels, a countdown self-clean cycle and short/long press classification on the menu key.
- Replaces the fixed 3-level controller. Sits between the board button/switch inputs and the fan driver, display and status LEDs.
- Single clock domain. An internal prescaler generates the slow tick used for debounce and all timers.

Parameters:
- NUM_LEVELS, 3, number of smoke levels (1..8).
- TICK_DIV, 1000000, clk cycles per tick (100 Hz at 100 MHz).
- DEBOUNCE_TICKS, 2, consecutive equal tick samples required to accept a menu level change.
- LONG_PRESS_TICKS, 200, hold duration in ticks that classifies a press as long.
- CLEAN_W, 16, width of the cleaning delay and countdown.
- TOP_TIMEOUT_TICKS, 6000, top-level dwell limit in ticks (used only with the optional feature).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous reset, active-low.
- power_on  in  1  level; low forces OFF.
- menu  in  1  raw menu key, asynchronous.
- mode_sel  in  NUM_LEVELS+1  one-hot selector; bit k<NUM_LEVELS selects level k+1, bit NUM_LEVELS selects cleaning.
- clean_delay  in  CLEAN_W  cleaning duration in ticks; sampled on entry to CLEANING.
- state  out  2  00 OFF, 01 STANDBY, 10 SMOKING, 11 CLEANING.
- smoke_lvl  out  NUM_LEVELS  one-hot active level; all zero outside SMOKING.
- clean_remaining  out  CLEAN_W  ticks left in CLEANING; 0 otherwise.
- clean_done  out  1  1-cycle pulse when a cleaning cycle completes.
- short_press  out  1  1-cycle pulse.
- long_press  out  1  1-cycle pulse.

Behaviour:
- Reset: while reset is low, all outputs are 0, state=OFF, and the prescaler, debouncer, hold counter and timers are cleared. Release is asynchronous-assert; the block resumes on the first clk edge after release.
- Prescaler: tick is a 1-cycle pulse every TICK_DIV clk cycles and free-runs from reset.
- menu input path:
  - 2-FF synchroniser on clk.
  - The debounced level changes only after DEBOUNCE_TICKS consecutive tick samples that differ from the current debounced value.
- Press classification, on the debounced signal:
  - Rising edge clears the hold counter; the counter increments on each tick while held and saturates at LONG_PRESS_TICKS.
  - Counter reaching LONG_PRESS_TICKS: long_press pulses once. Releasing after that produces no short_press.
  - Release with counter < LONG_PRESS_TICKS: short_press pulses on the cycle after the debounced fall. A zero-tick hold still counts as a short press.
- FSM: all transitions take effect on the clk edge after the qualifying event. Priority is power_on low > long_press > short_press > timers.
  - Any state with power_on=0 → OFF. Clear smoke_lvl and the countdown.
  - OFF with power_on=1 → STANDBY.
  - STANDBY + short_press:
    - mode_sel exactly one-hot at level bit k → SMOKING, smoke_lvl=1<<k.
    - mode_sel = cleaning bit → CLEANING, clean_remaining=clean_delay.
    - zero or multi-hot → ignored, stay in STANDBY.
  - SMOKING + short_press:
    - mode_sel one-hot at a different level → switch smoke_lvl directly, stay in SMOKING.
    - any other mode_sel → STANDBY.
  - CLEANING:
    - clean_remaining decrements on each tick.
    - On the tick where it reaches 0 (or on entry with clean_delay=0): clean_done pulses and the FSM goes to STANDBY on the same edge.
    - short_press is ignored in CLEANING.
  - long_press in STANDBY, SMOKING or CLEANING → STANDBY. An aborted clean does not pulse clean_done. long_press in OFF is ignored.
- mode_sel and clean_delay are sampled only at the transition edge; changes at other times have no effect.

Optional Feature:
- Macro: HOOD_TOP_TIMEOUT_EN.
- Defined:
  - While in SMOKING at level NUM_LEVELS, a dwell counter increments per tick.
  - At TOP_TIMEOUT_TICKS the FSM moves to level NUM_LEVELS-1, or to STANDBY if NUM_LEVELS=1.
  - The counter clears on any level change or on leaving SMOKING.
- Not defined: the top level persists indefinitely; no dwell counter logic is generated.

Test Plan:
- Test parameters: TICK_DIV=4, DEBOUNCE_TICKS=2, LONG_PRESS_TICKS=10, NUM_LEVELS=3.
- Reset low mid-CLEANING with clean_remaining=7 → all outputs 0 immediately; after release with power_on=1, state=01 on the next edge.
- power_on=1, mode_sel=4'b0010, 3-tick press → short_press pulse, state=10, smoke_lvl=3'b010. Then mode_sel=4'b0100 plus a short press → smoke_lvl=3'b100, state stays 10.
- mode_sel=4'b1000, clean_delay=5, short press → state=11, clean_remaining counts 5..0 over 5 ticks, clean_done pulses once, state=01. Repeat with clean_delay=0 → done on the entry cycle.
- In SMOKING, hold menu 15 ticks → long_press pulses at tick 10, state=01, no short_press on release. In CLEANING, long press → state=01 with no clean_done.
- menu glitch shorter than 2 ticks → no press pulses. mode_sel=4'b0011 with a short press in STANDBY → state stays 01. power_on=0 in the same cycle as short_press → state=00.
- With HOOD_TOP_TIMEOUT_EN and TOP_TIMEOUT_TICKS=20: level 3 held 20 ticks → smoke_lvl=3'b010.
